// File: rtl/fsm_event_sched_pkg.sv
// Shared encodings for the event scheduler: controlled-FSM one-hot states,
// event codes, controller state enum and small decode helpers.
package fsm_event_sched_pkg;

  // One-hot encodings of the controlled FSM's present state
  localparam logic [3:0] FSM_INIT      = 4'b1000;
  localparam logic [3:0] FSM_SECONDRY  = 4'b0100;
  localparam logic [3:0] FSM_BLACKHOLE = 4'b0010;
  localparam logic [3:0] FSM_THIRD     = 4'b0001;

  // Per-requester 2-bit event codes
  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_A    = 2'b01;
  localparam logic [1:0] EV_B    = 2'b10;
  localparam logic [1:0] EV_C    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_HOLD,
    S_RECOVER
  } ctrl_state_t;

  // True when exactly one bit of the 4-bit state vector is set
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Index of a one-hot 3-bit grant (0 when no bit is set)
  function automatic logic [1:0] grant_idx(input logic [2:0] g);
    if (g[2])      return 2'd2;
    else if (g[1]) return 2'd1;
    else           return 2'd0;
  endfunction

endpackage

// File: rtl/fsm_event_sched_rr_arb3.sv
// Three-way round-robin arbiter: picks the lowest-index active request at or
// after ptr, wrapping 2 -> 0. Purely combinational.
module rr_arb3
  import fsm_event_sched_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] grant
);

  // Rotate the priority order according to the pointer
  always_comb begin
    grant = 3'b000;
    case (ptr)
      2'd1: begin
        if (req[1])      grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      2'd2: begin
        if (req[2])      grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if (req[0])      grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/fsm_event_sched.sv
// Event scheduler: accepts one requester event at a time, strobes it into the
// controlled FSM, watches for the FSM getting stuck in BLACKHOLE (or taking an
// illegal encoding) and forces a recovery reset when needed.
module fsm_event_sched
  import fsm_event_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req_valid,
  input  logic [5:0] req_event,
  output logic [2:0] req_ready,
  input  logic [3:0] fsm_state,
  output logic       ev_a,
  output logic       ev_b,
  output logic       ev_c,
  output logic       fsm_reset,
  output logic       busy,
  output logic [7:0] recover_cnt,
  output logic       err
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  ctrl_state_t state;
  logic [1:0]  rr_ptr;
  logic [7:0]  hold_cnt;
  logic [2:0]  grant;
  logic [1:0]  gidx;
  logic [1:0]  gcode;

  rr_arb3 u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Ready is a handshake: only offered while idle, and never during reset
  assign req_ready = (state == S_IDLE && !reset) ? grant : 3'b000;
  assign busy      = (state != S_IDLE);
  assign gidx      = grant_idx(grant);

  // Select the event code belonging to the granted requester
  always_comb begin
    gcode = EV_NONE;
    case (gidx)
      2'd0:    gcode = req_event[1:0];
      2'd1:    gcode = req_event[3:2];
      2'd2:    gcode = req_event[5:4];
      default: gcode = EV_NONE;
    endcase
  end

  // Controller FSM with registered strobes, recovery pulse and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rr_ptr      <= 2'd0;
      hold_cnt    <= 8'd0;
      ev_a        <= 1'b0;
      ev_b        <= 1'b0;
      ev_c        <= 1'b0;
      fsm_reset   <= 1'b0;
      recover_cnt <= 8'd0;
      err         <= 1'b0;
    end else begin
      ev_a      <= 1'b0;
      ev_b      <= 1'b0;
      ev_c      <= 1'b0;
      fsm_reset <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req_ready) begin
            // The strobe registers double as the latched event code
            ev_a   <= (gcode == EV_A);
            ev_b   <= (gcode == EV_B);
            ev_c   <= (gcode == EV_C);
            rr_ptr <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_SETTLE;
        S_SETTLE: begin
          if (fsm_state == FSM_BLACKHOLE) begin
            hold_cnt <= 8'd1;
            state    <= S_HOLD;
          end else if (is_onehot4(fsm_state)) begin
            state <= S_IDLE;
          end else begin
            err       <= 1'b1;
            fsm_reset <= 1'b1;
            state     <= S_RECOVER;
          end
        end
        S_HOLD: begin
          if (fsm_state == FSM_BLACKHOLE) begin
            if (hold_cnt + 8'd1 >= TIMEOUT_C) begin
              hold_cnt  <= 8'd0;
              fsm_reset <= 1'b1;
              state     <= S_RECOVER;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end else begin
            hold_cnt <= 8'd0;
            state    <= S_IDLE;
          end
        end
        S_RECOVER: begin
          if (recover_cnt != 8'hFF) recover_cnt <= recover_cnt + 8'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_event_sched.sv
// Directed bench for fsm_event_sched: a cycle table for the basic request /
// strobe / settle flow, plus hand sequences for lockup recovery, illegal
// state, reset during ISSUE and round-robin fairness.
module tb_fsm_event_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req_valid;
  logic [5:0] req_event;
  logic [2:0] req_ready;
  logic [3:0] fsm_state;
  logic       ev_a, ev_b, ev_c;
  logic       fsm_reset;
  logic       busy;
  logic [7:0] recover_cnt;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fsm_event_sched #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_event   (req_event),
    .req_ready   (req_ready),
    .fsm_state   (fsm_state),
    .ev_a        (ev_a),
    .ev_b        (ev_b),
    .ev_c        (ev_c),
    .fsm_reset   (fsm_reset),
    .busy        (busy),
    .recover_cnt (recover_cnt),
    .err         (err)
  );

  typedef struct {
    logic [2:0] rv;
    logic [5:0] re;
    logic [3:0] fs;
    logic [2:0] rdy;
    logic [2:0] ev;   // {c,b,a}
    logic       frst;
    logic       bsy;
    logic [7:0] rc;
    logic       er;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(input logic [2:0] rv, input logic [5:0] re,
                              input logic [3:0] fs, input logic [2:0] rdy,
                              input logic [2:0] ev, input logic bsy);
    vec_t v;
    v.rv = rv; v.re = re; v.fs = fs; v.rdy = rdy; v.ev = ev;
    v.frst = 1'b0; v.bsy = bsy; v.rc = 8'd0; v.er = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] rv, input logic [5:0] re, input logic [3:0] fs);
    req_valid = rv;
    req_event = re;
    fsm_state = fs;
    #1;
  endtask

  task automatic chk_all(input string name, input logic [2:0] rdy, input logic [2:0] ev,
                         input logic frst, input logic bsy, input logic [7:0] rc,
                         input logic er);
    chk({name, ".ready"}, 32'(req_ready), 32'(rdy));
    chk({name, ".ev"}, 32'({ev_c, ev_b, ev_a}), 32'(ev));
    chk({name, ".fsm_reset"}, 32'(fsm_reset), 32'(frst));
    chk({name, ".busy"}, 32'(busy), 32'(bsy));
    chk({name, ".recover_cnt"}, 32'(recover_cnt), 32'(rc));
    chk({name, ".err"}, 32'(err), 32'(er));
  endtask

  initial begin
    // Basic flow, one row per clock cycle
    tbl[0]  = mk(3'b000, 6'b000000, 4'b1000, 3'b000, 3'b000, 1'b0);
    tbl[1]  = mk(3'b001, 6'b000001, 4'b1000, 3'b001, 3'b000, 1'b0);
    tbl[2]  = mk(3'b000, 6'b000000, 4'b1000, 3'b000, 3'b001, 1'b1);
    tbl[3]  = mk(3'b000, 6'b000000, 4'b1000, 3'b000, 3'b000, 1'b1);
    tbl[4]  = mk(3'b000, 6'b000000, 4'b1000, 3'b000, 3'b000, 1'b0);
    tbl[5]  = mk(3'b010, 6'b001000, 4'b1000, 3'b010, 3'b000, 1'b0);
    tbl[6]  = mk(3'b000, 6'b000000, 4'b1000, 3'b000, 3'b010, 1'b1);
    tbl[7]  = mk(3'b000, 6'b000000, 4'b0100, 3'b000, 3'b000, 1'b1);
    tbl[8]  = mk(3'b100, 6'b110000, 4'b0100, 3'b100, 3'b000, 1'b0);
    tbl[9]  = mk(3'b000, 6'b000000, 4'b0100, 3'b000, 3'b100, 1'b1);
    tbl[10] = mk(3'b000, 6'b000000, 4'b0001, 3'b000, 3'b000, 1'b1);
    tbl[11] = mk(3'b011, 6'b000000, 4'b1000, 3'b001, 3'b000, 1'b0);
    tbl[12] = mk(3'b010, 6'b000000, 4'b1000, 3'b000, 3'b000, 1'b1);
    tbl[13] = mk(3'b010, 6'b000000, 4'b1000, 3'b000, 3'b000, 1'b1);
    tbl[14] = mk(3'b010, 6'b000100, 4'b1000, 3'b010, 3'b000, 1'b0);
    tbl[15] = mk(3'b000, 6'b000000, 4'b1000, 3'b000, 3'b001, 1'b1);
    tbl[16] = mk(3'b000, 6'b000000, 4'b1000, 3'b000, 3'b000, 1'b1);
    tbl[17] = mk(3'b001, 6'b000010, 4'b1000, 3'b001, 3'b000, 1'b0);
    tbl[18] = mk(3'b000, 6'b000000, 4'b1000, 3'b000, 3'b010, 1'b1);
    tbl[19] = mk(3'b000, 6'b000000, 4'b1000, 3'b000, 3'b000, 1'b1);
    // Early escape from BLACKHOLE after three cycles
    tbl[20] = mk(3'b001, 6'b000001, 4'b1000, 3'b001, 3'b000, 1'b0);
    tbl[21] = mk(3'b000, 6'b000000, 4'b1000, 3'b000, 3'b001, 1'b1);
    tbl[22] = mk(3'b000, 6'b000000, 4'b0010, 3'b000, 3'b000, 1'b1);
    tbl[23] = mk(3'b000, 6'b000000, 4'b0010, 3'b000, 3'b000, 1'b1);
    tbl[24] = mk(3'b000, 6'b000000, 4'b0010, 3'b000, 3'b000, 1'b1);
    tbl[25] = mk(3'b000, 6'b000000, 4'b1000, 3'b000, 3'b000, 1'b1);
    tbl[26] = mk(3'b000, 6'b000000, 4'b1000, 3'b000, 3'b000, 1'b0);

    // Reset state, with requests pending to show ready stays low
    reset = 1'b1;
    drive(3'b111, 6'b011011, 4'b1000);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 3'b000, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0);
    reset = 1'b0;
    drive(3'b000, 6'b000000, 4'b1000);

    for (int i = 0; i < 27; i++) begin
      cyc();
      drive(tbl[i].rv, tbl[i].re, tbl[i].fs);
      chk_all($sformatf("row%0d", i), tbl[i].rdy, tbl[i].ev, tbl[i].frst,
              tbl[i].bsy, tbl[i].rc, tbl[i].er);
    end

    // Lockup: B issued, FSM parks in BLACKHOLE, recovery after 8 cycles
    cyc(); drive(3'b010, 6'b001000, 4'b1000);
    chk("lock.ready", 32'(req_ready), 32'h2);
    cyc(); drive(3'b000, 6'b000000, 4'b1000);
    chk("lock.ev", 32'({ev_c, ev_b, ev_a}), 32'h2);
    for (int i = 0; i < 8; i++) begin
      cyc(); drive(3'b000, 6'b000000, 4'b0010);
      chk($sformatf("lock.wait%0d.fsm_reset", i), 32'(fsm_reset), 32'h0);
      chk($sformatf("lock.wait%0d.busy", i), 32'(busy), 32'h1);
    end
    cyc(); drive(3'b000, 6'b000000, 4'b0010);
    chk("lock.pulse", 32'(fsm_reset), 32'h1);
    cyc(); drive(3'b000, 6'b000000, 4'b1000);
    chk_all("lock.after", 3'b000, 3'b000, 1'b0, 1'b0, 8'd1, 1'b0);

    // Illegal fsm_state sampled in SETTLE
    cyc(); drive(3'b100, 6'b010000, 4'b1000);
    chk("ill.ready", 32'(req_ready), 32'h4);
    cyc(); drive(3'b000, 6'b000000, 4'b1000);
    chk("ill.ev", 32'({ev_c, ev_b, ev_a}), 32'h1);
    cyc(); drive(3'b000, 6'b000000, 4'b0110);
    chk("ill.settle.err", 32'(err), 32'h0);
    cyc(); drive(3'b000, 6'b000000, 4'b1000);
    chk("ill.pulse", 32'(fsm_reset), 32'h1);
    chk("ill.err", 32'(err), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_all($sformatf("ill.sticky%0d", i), 3'b000, 3'b000, 1'b0, 1'b0, 8'd2, 1'b1);
    end

    // Reset asserted mid-ISSUE, pointer left at 1 beforehand
    cyc(); drive(3'b001, 6'b000001, 4'b1000);
    chk("rst.ready", 32'(req_ready), 32'h1);
    cyc(); drive(3'b111, 6'b011011, 4'b1000);
    chk("rst.issue.ev", 32'({ev_c, ev_b, ev_a}), 32'h1);
    reset = 1'b1;
    #1;
    chk_all("rst.async", 3'b000, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc();
    chk_all("rst.held", 3'b000, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0);
    reset = 1'b0;
    #1;

    // Fairness from the freshly reset pointer: 0,1,2,0,1,2 three cycles apart
    // req_event = {A, B, C} for requesters {2, 1, 0}
    for (int c = 0; c < 18; c++) begin
      logic [2:0] exp_rdy;
      logic [2:0] exp_ev;
      int         who;
      if (c > 0) cyc();
      who = (c / 3) % 3;
      exp_rdy = (c % 3 == 0) ? (3'b001 << who) : 3'b000;
      exp_ev  = (c % 3 == 1) ? (3'b100 >> who) : 3'b000;
      chk($sformatf("fair%0d.ready", c), 32'(req_ready), 32'(exp_rdy));
      chk($sformatf("fair%0d.ev", c), 32'({ev_c, ev_b, ev_a}), 32'(exp_ev));
      chk($sformatf("fair%0d.fsm_reset", c), 32'(fsm_reset), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
